demux_dispatch: RTL and testbench

Sequential 1-to-4 data distributor: accepts one word per handshake on a single input channel and routes it, by the 2-bit select {s0,s1}, into one of four single-entry output holding registers, each with its own valid/ready handshake. It is the fan-out counterpart of the 4:1 selection path in the data processing unit, delivering results back to the four per-source lanes. It also keeps a wrap-around count of accepted words for status.

---
 rtl/demux_dispatch.sv | 149 ++++++++++++++
 tb/tb_demux_dispatch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch.sv
// ---------------------------------------------------------------------------
// demux_dispatch
//
// Sequential 1-to-4 data distributor. One input word is accepted per
// valid/ready handshake. It is routed by the 2-bit select {s0,s1} into one of
// four single-entry holding registers. Each holding register has its own
// valid/ready handshake. A wrap-around 8-bit counter tracks accepted words.
//
// Optional feature macro: DEMUX_BCAST_EN
//   When defined, bcast=1 loads all four channels from one input word.
//   When undefined, bcast is ignored.
//
// Ports
//   clk                   clock, rising edge
//   rst                   asynchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   in_data   [W-1:0]     input word
//   s0, s1                channel select, ch = {s0,s1}
//   bcast                 broadcast request (only with DEMUX_BCAST_EN)
//   out_valid [3:0]       bit k: channel k holds a word
//   out_ready [3:0]       bit k: consumer k takes the word this cycle
//   out_data0..3 [W-1:0]  channel holding registers
//   acc_cnt   [7:0]       accepted words, modulo 256
// ---------------------------------------------------------------------------
module demux_dispatch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         s0,
  input  logic         s1,
  input  logic         bcast,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [W-1:0] out_data0,
  output logic [W-1:0] out_data1,
  output logic [W-1:0] out_data2,
  output logic [W-1:0] out_data3,
  output logic [7:0]   acc_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e    r_state     [4];
  ch_state_e    w_state_nxt [4];
  logic [W-1:0] r_data      [4];
  logic [7:0]   r_acc_cnt;

  logic [1:0]   w_ch;
  logic [3:0]   w_valid;
  logic [3:0]   w_free;     // channel can take a word this cycle
  logic [3:0]   w_target;   // channels addressed by the current input word
  logic [3:0]   w_load;
  logic         w_in_ready;
  logic         w_accept;

  assign w_ch = {s0, s1};

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_valid[k] = (r_state[k] == FULL);
    end
  end

  // A FULL channel is still free when its consumer drains it this cycle.
  assign w_free = ~w_valid | out_ready;

  // NOTE: every output of a combinational block gets a default at the top so
  // that no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    w_target   = 4'b0001 << w_ch;
    w_in_ready = w_free[w_ch];
`ifdef DEMUX_BCAST_EN
    // Broadcast must wait until every channel can take the word at once.
    if (bcast) begin
      w_target   = 4'b1111;
      w_in_ready = &w_free;
    end
`endif
  end

`ifndef DEMUX_BCAST_EN
  logic w_unused_bcast;
  assign w_unused_bcast = bcast;
`endif

  assign w_accept = in_valid & w_in_ready;
  assign w_load   = w_target & {4{w_accept}};

  // Per-channel EMPTY/FULL machine; a load wins over a drain in the same cycle.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_state_nxt[k] = r_state[k];
      case (r_state[k])
        EMPTY:   if (w_load[k]) w_state_nxt[k] = FULL;
        FULL: begin
          if (w_load[k])         w_state_nxt[k] = FULL;
          else if (out_ready[k]) w_state_nxt[k] = EMPTY;
        end
        default: w_state_nxt[k] = EMPTY;
      endcase
    end
  end

  // NOTE: clocked blocks use non-blocking assignments only, so every register
  // samples its inputs from before the edge regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) r_state[k] <= EMPTY;
    end else begin
      for (int k = 0; k < 4; k++) r_state[k] <= w_state_nxt[k];
    end
  end

  // NOTE: the holding registers are small and must read as zero after reset,
  // so they sit in the reset domain rather than being left as plain storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) r_data[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_load[k]) r_data[k] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_cnt <= 8'd0;
    end else if (w_accept) begin
      r_acc_cnt <= r_acc_cnt + 8'd1;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_valid;
  assign out_data0 = r_data[0];
  assign out_data1 = r_data[1];
  assign out_data2 = r_data[2];
  assign out_data3 = r_data[3];
  assign acc_cnt   = r_acc_cnt;

endmodule

// File: tb/tb_demux_dispatch.sv
// ---------------------------------------------------------------------------
// tb_demux_dispatch
//
// Self-checking bench for demux_dispatch. Directed steps follow the block's
// intended use cases, then randomized traffic. Expected values come from a
// behavioural model of four one-word mailboxes and a modulo-256 counter.
// Honours DEMUX_BCAST_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_demux_dispatch;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         s0;
  logic         s1;
  logic         bcast;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data0;
  logic [W-1:0] out_data1;
  logic [W-1:0] out_data2;
  logic [W-1:0] out_data3;
  logic [7:0]   acc_cnt;

  always #5 clk = ~clk;

  demux_dispatch #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .s0        (s0),
    .s1        (s1),
    .bcast     (bcast),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .acc_cnt   (acc_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference: four mailboxes, each either holding a word or empty.
  bit         m_full [4];
  logic [7:0] m_word [4];
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_word[k] = 8'h00;
    end
    m_cnt = 0;
  endtask

  // Set of mailboxes the current input word is addressed to.
  function automatic logic [3:0] m_targets();
    logic [3:0] t;
    t = 4'b0000;
    t[{s0, s1}] = 1'b1;
`ifdef DEMUX_BCAST_EN
    if (bcast) t = 4'b1111;
`endif
    return t;
  endfunction

  // The word may enter only if no addressed mailbox stays occupied.
  function automatic logic m_ready();
    logic [3:0] t;
    t = m_targets();
    for (int k = 0; k < 4; k++) begin
      if (t[k] && m_full[k] && !out_ready[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [3:0] m_valid_vec();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_full[k];
    return v;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ":out_valid"}, 32'(out_valid), 32'(m_valid_vec()));
    check({tag, ":out_data0"}, 32'(out_data0), 32'(m_word[0]));
    check({tag, ":out_data1"}, 32'(out_data1), 32'(m_word[1]));
    check({tag, ":out_data2"}, 32'(out_data2), 32'(m_word[2]));
    check({tag, ":out_data3"}, 32'(out_data3), 32'(m_word[3]));
    check({tag, ":acc_cnt"},   32'(acc_cnt),   32'(m_cnt));
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] d,
                       input logic [3:0] ordy, input logic bc);
    in_valid  = v;
    {s0, s1}  = ch;
    in_data   = d;
    out_ready = ordy;
    bcast     = bc;
  endtask

  // One clock cycle: check in_ready before the edge, advance the model across
  // the edge, then check every registered output just after it.
  task automatic step(input string tag);
    logic       exp_rdy;
    logic       acc;
    logic [3:0] tgt;
    logic [3:0] ordy;
    logic [7:0] d;
    #1;
    exp_rdy = m_ready();
    check({tag, ":in_ready"}, 32'(in_ready), 32'(exp_rdy));
    acc  = in_valid && exp_rdy;
    tgt  = m_targets();
    ordy = out_ready;
    d    = in_data;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (m_full[k] && ordy[k]) m_full[k] = 1'b0;
      if (acc && tgt[k]) begin
        m_full[k] = 1'b1;
        m_word[k] = d;
      end
    end
    if (acc) m_cnt = (m_cnt + 1) % 256;
    check_outputs(tag);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 4'h0, 1'b0);
    m_reset();
    #12;
    check_outputs("reset");
    check("reset:in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Routing by select on consecutive cycles
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 8'(8'hA0 + i), 4'hF, 1'b0);
      step("route");
    end
    check("route:count4", 32'(acc_cnt), 32'd4);

    // Full-channel stall, then same-cycle drain and reload
    drive(1'b1, 2'd1, 8'h55, 4'h0, 1'b0);
    step("stall_load");
    drive(1'b1, 2'd1, 8'h66, 4'h0, 1'b0);
    step("stall_block");
    check("stall:held55", 32'(out_data1), 32'h55);
    drive(1'b1, 2'd1, 8'h66, 4'b0010, 1'b0);
    step("stall_reload");
    check("stall:data66", 32'(out_data1), 32'h66);
    check("stall:valid1", 32'(out_valid[1]), 32'd1);

    // Independence of channels
    drive(1'b0, 2'd0, 8'h00, 4'b0010, 1'b0);
    step("indep_drain");
    drive(1'b1, 2'd0, 8'h11, 4'h0, 1'b0);
    step("indep_ch0");
    drive(1'b1, 2'd3, 8'h77, 4'h0, 1'b0);
    step("indep_ch3");
    check("indep:valid", 32'(out_valid), 32'b1001);
    check("indep:data0", 32'(out_data0), 32'h11);

    // Broadcast against a FULL channel 2
    drive(1'b0, 2'd0, 8'h00, 4'hF, 1'b0);
    step("bc_drain");
    drive(1'b1, 2'd2, 8'h22, 4'h0, 1'b0);
    step("bc_fill2");
    drive(1'b1, 2'd2, 8'h3C, 4'h0, 1'b1);
    step("bc_stall");
    check("bc:stall_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 2'd2, 8'h3C, 4'b0100, 1'b1);
    step("bc_accept");
`ifdef DEMUX_BCAST_EN
    check("bc:valid_all", 32'(out_valid), 32'b1111);
    check("bc:data0", 32'(out_data0), 32'h3C);
    check("bc:data3", 32'(out_data3), 32'h3C);
`else
    check("bc:valid_ch2", 32'(out_valid), 32'b0100);
    check("bc:data2", 32'(out_data2), 32'h3C);
`endif

    // Asynchronous reset in the middle of a stalled transfer to channel 2
    drive(1'b1, 2'd2, 8'h99, 4'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    check_outputs("rst_async");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_async:in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Counter wrap: 256 accepts return to 0, the next gives 1
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 4'hF, 1'b0);
      step("wrap");
    end
    check("wrap:zero", 32'(acc_cnt), 32'd0);
    drive(1'b1, 2'd0, 8'h01, 4'hF, 1'b0);
    step("wrap_257");
    check("wrap:one", 32'(acc_cnt), 32'd1);

    // Randomized traffic with back-pressure and occasional broadcast
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
            4'($urandom), 1'($urandom_range(0, 7) == 0));
      step("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
